mem_wr_merge: RTL

//  Write-side front end for the 2-read/1-write register memory. Merges two

---
 rtl/mem_wr_merge.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_wr_merge.sv
// mem_wr_merge: merges two write requesters onto a single memory write port.
// Each requester feeds its own FIFO; a round-robin arbiter pops at most one
// head per cycle into a registered write port (we0/wr_addr0/wr_din0).
//
// Handshake: reqN_ready = (fifoN_count != DEPTH). It depends only on FIFO
// state and never on reqN_valid. A transfer happens on a posedge where
// valid && ready. Valid may drop without a transfer. A full FIFO keeps ready
// low even in a cycle where it is popped, so there is no pass-through path.
module mem_wr_merge #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0_valid,
    output logic                       req0_ready,
    input  logic [AW-1:0]              req0_addr,
    input  logic [DW-1:0]              req0_data,
    input  logic                       req1_valid,
    output logic                       req1_ready,
    input  logic [AW-1:0]              req1_addr,
    input  logic [DW-1:0]              req1_data,
    output logic                       we0,
    output logic [AW-1:0]              wr_addr0,
    output logic [DW-1:0]              wr_din0,
    output logic [$clog2(DEPTH):0]     fifo0_count,
    output logic [$clog2(DEPTH):0]     fifo1_count,
    output logic                       busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + DW;

    // Each entry is stored as {addr, data}.
    logic [EW-1:0] fifo0_mem [DEPTH];
    logic [EW-1:0] fifo1_mem [DEPTH];
    logic [PW-1:0] wr_ptr0, rd_ptr0, wr_ptr1, rd_ptr1;

    logic          push0, push1;
    logic          grant0, grant1;
    logic          nonempty0, nonempty1;
    logic          rr_ptr;          // 0: port0 wins a tie, 1: port1 wins a tie
    logic [EW-1:0] head;

    assign req0_ready = (fifo0_count != CW'(DEPTH));
    assign req1_ready = (fifo1_count != CW'(DEPTH));
    assign push0      = req0_valid && req0_ready;
    assign push1      = req1_valid && req1_ready;
    assign nonempty0  = (fifo0_count != '0);
    assign nonempty1  = (fifo1_count != '0);
    assign busy       = nonempty0 || nonempty1 || we0;

    // Round-robin choice among the non-empty FIFO heads.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (nonempty0 && nonempty1) begin
            if (rr_ptr) grant1 = 1'b1;
            else        grant0 = 1'b1;
        end else if (nonempty0) begin
            grant0 = 1'b1;
        end else if (nonempty1) begin
            grant1 = 1'b1;
        end
    end

    assign head = grant1 ? fifo1_mem[rd_ptr1] : fifo0_mem[rd_ptr0];

    // FIFO storage. The data is left unreset because it is only read when the count says it is valid.
    always_ff @(posedge clk) begin
        if (push0) fifo0_mem[wr_ptr0] <= {req0_addr, req0_data};
        if (push1) fifo1_mem[wr_ptr1] <= {req1_addr, req1_data};
    end

    // Port0 FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr0     <= '0;
            rd_ptr0     <= '0;
            fifo0_count <= '0;
        end else begin
            if (push0)  wr_ptr0 <= wr_ptr0 + PW'(1);
            if (grant0) rd_ptr0 <= rd_ptr0 + PW'(1);
            case ({push0, grant0})
                2'b10:   fifo0_count <= fifo0_count + CW'(1);
                2'b01:   fifo0_count <= fifo0_count - CW'(1);
                default: fifo0_count <= fifo0_count;
            endcase
        end
    end

    // Port1 FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr1     <= '0;
            rd_ptr1     <= '0;
            fifo1_count <= '0;
        end else begin
            if (push1)  wr_ptr1 <= wr_ptr1 + PW'(1);
            if (grant1) rd_ptr1 <= rd_ptr1 + PW'(1);
            case ({push1, grant1})
                2'b10:   fifo1_count <= fifo1_count + CW'(1);
                2'b01:   fifo1_count <= fifo1_count - CW'(1);
                default: fifo1_count <= fifo1_count;
            endcase
        end
    end

    // The RR pointer moves away from the winner, and only when a grant is made.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= 1'b0;
        end else if (grant0) begin
            rr_ptr <= 1'b1;
        end else if (grant1) begin
            rr_ptr <= 1'b0;
        end
    end

    // Registered write port. Address and data hold while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we0      <= 1'b0;
            wr_addr0 <= '0;
            wr_din0  <= '0;
        end else begin
            we0 <= grant0 || grant1;
            if (grant0 || grant1) begin
                wr_addr0 <= head[EW-1:DW];
                wr_din0  <= head[DW-1:0];
            end
        end
    end

endmodule
